// File: rtl/sw_btn_input.sv
// Switch/button input block: 2-flop sync, per-line debounce, sticky rising-edge button
// events and a registered read port. Optional `SW_BTN_IRQ_EN adds a one-cycle irq pulse.

module sw_btn_deb #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd20000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);
    logic        sync1, sync2;
    logic [15:0] cnt;
    logic        done;

    // done marks the edge where a persistent difference is accepted
    assign done = (sync2 != stable) && (cnt == DEBOUNCE_CYCLES - 16'd1);
    assign rise = done && sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (done) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end
endmodule

module sw_btn_input #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd20000,
    parameter int          BTN_W           = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      sw_i,
    input  logic [BTN_W-1:0] btn_i,
    input  logic             rd_en,
    input  logic [1:0]       rd_addr,
    output logic [31:0]      rd_data,
    output logic [15:0]      sw_stable,
    output logic             evt_pending
`ifdef SW_BTN_IRQ_EN
    ,
    output logic             irq
`endif
);
    localparam int NUM_LINES = 16 + BTN_W;

    logic [NUM_LINES-1:0] raw, stable, rise;
    logic [BTN_W-1:0]     stable_btn, rise_btn, evt, evt_clr;
    logic [31:0]          rd_next;

    assign raw        = {btn_i, sw_i};
    assign sw_stable  = stable[15:0];
    assign stable_btn = stable[NUM_LINES-1:16];
    assign rise_btn   = rise[NUM_LINES-1:16];

    genvar i;
    generate
        for (i = 0; i < NUM_LINES; i++) begin : g_lane
            sw_btn_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
                .clk    (clk),
                .rst    (rst),
                .raw    (raw[i]),
                .stable (stable[i]),
                .rise   (rise[i])
            );
        end
    endgenerate

    assign evt_pending = |evt;

    // Only the bits returned by an addr-2 read are cleared; a same-edge rise survives.
    assign evt_clr = (rd_en && rd_addr == 2'd2) ? evt : '0;

    always_comb begin
        rd_next = '0;
        case (rd_addr)
            2'd0: rd_next[15:0]      = sw_stable;
            2'd1: rd_next[BTN_W-1:0] = stable_btn;
            2'd2: rd_next[BTN_W-1:0] = evt;
            2'd3: rd_next[1:0]       = {evt_pending, |stable_btn};
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt     <= '0;
            rd_data <= '0;
        end else begin
            evt <= (evt & ~evt_clr) | rise_btn;
            if (rd_en) rd_data <= rd_next;
        end
    end

`ifdef SW_BTN_IRQ_EN
    logic pend_d;

    // Pulse once on the zero -> non-zero transition of the event set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_d <= 1'b0;
            irq    <= 1'b0;
        end else begin
            pend_d <= evt_pending;
            irq    <= evt_pending && !pend_d;
        end
    end
`endif
endmodule

// File: tb/tb_sw_btn_input.sv
// Directed bench for sw_btn_input with DEBOUNCE_CYCLES=4, BTN_W=5.
module tb_sw_btn_input;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw_i;
    logic [4:0]  btn_i;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic [31:0] rd_data;
    logic [15:0] sw_stable;
    logic        evt_pending;
`ifdef SW_BTN_IRQ_EN
    logic        irq;
`endif

    int errors = 0;
    int checks = 0;

    sw_btn_input #(.DEBOUNCE_CYCLES(16'd4), .BTN_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_i        (sw_i),
        .btn_i       (btn_i),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .sw_stable   (sw_stable),
        .evt_pending (evt_pending)
`ifdef SW_BTN_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        tick(1);
        rd_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b0; sw_i = 16'hFFFF; btn_i = '0; rd_en = 1'b0; rd_addr = '0;

        // reset held with switches high
        tick(5);
        chk("rst_sw", {16'b0, sw_stable}, 32'h0);
        chk("rst_rd", rd_data, 32'h0);
        chk("rst_pend", {31'b0, evt_pending}, 32'h0);
        rst = 1'b1;
        tick(5);
        chk("rel_sw_early", {16'b0, sw_stable}, 32'h0);
        tick(1);
        chk("rel_sw_6", {16'b0, sw_stable}, 32'hFFFF);

        // glitch reject, then a real change on sw[3]
        sw_i = 16'h0000;
        tick(8);
        chk("sw_clear", {16'b0, sw_stable}, 32'h0);
        sw_i = 16'h0008;
        tick(3);
        sw_i = 16'h0000;
        tick(8);
        chk("glitch", {16'b0, sw_stable}, 32'h0);
        sw_i = 16'h0008;
        tick(5);
        chk("sw3_early", {16'b0, sw_stable}, 32'h0);
        tick(1);
        chk("sw3_6", {16'b0, sw_stable}, 32'h0008);

        // read map
        sw_i = 16'hA5C3; btn_i = 5'b10001;
        tick(6);
        chk("map_pend", {31'b0, evt_pending}, 32'h1);
`ifdef SW_BTN_IRQ_EN
        chk("irq_pre", {31'b0, irq}, 32'h0);
        tick(1);
        chk("irq_pulse", {31'b0, irq}, 32'h1);
        tick(1);
        chk("irq_one", {31'b0, irq}, 32'h0);
`endif
        rd(2'd0); chk("rd0", rd_data, 32'h0000A5C3);
        rd(2'd1); chk("rd1", rd_data, 32'h11);
        rd(2'd3); chk("rd3", rd_data, 32'h3);
        tick(3);
        chk("rd_hold", rd_data, 32'h3);
        rd(2'd2); chk("rd2_both", rd_data, 32'h11);
        chk("pend_clr", {31'b0, evt_pending}, 32'h0);
        btn_i = '0;
        tick(8);
        chk("fall_ignored", {31'b0, evt_pending}, 32'h0);
        rd(2'd1); chk("rd1_zero", rd_data, 32'h0);

        // single button press and clear-on-read
        btn_i = 5'b00100;
        tick(6);
        chk("btn2_pend", {31'b0, evt_pending}, 32'h1);
        btn_i = '0;
        tick(8);
        chk("btn2_keep", {31'b0, evt_pending}, 32'h1);
        rd(2'd2); chk("btn2_rd", rd_data, 32'h4);
        chk("btn2_clr", {31'b0, evt_pending}, 32'h0);
        rd(2'd2); chk("btn2_rd_again", rd_data, 32'h0);

        // btn0 rise lands on the same edge as a read of evt=00010
        btn_i = 5'b00010;
        tick(6);
        chk("btn1_pend", {31'b0, evt_pending}, 32'h1);
        tick(1);
`ifdef SW_BTN_IRQ_EN
        chk("irq_second_first", {31'b0, irq}, 32'h1);
`endif
        btn_i = 5'b00011;
        tick(5);
        rd(2'd2);
        chk("sim_rd", rd_data, 32'h2);
        chk("sim_pend", {31'b0, evt_pending}, 32'h1);
`ifdef SW_BTN_IRQ_EN
        chk("irq_no_repeat", {31'b0, irq}, 32'h0);
        tick(1);
        chk("irq_no_repeat2", {31'b0, irq}, 32'h0);
`endif
        rd(2'd0); chk("pre_arst_rd", rd_data, 32'h0000A5C3);

        // async reset while sw debounce is counting, evt=00001 pending
        sw_i = 16'h00FF;
        tick(3);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_sw", {16'b0, sw_stable}, 32'h0);
        chk("arst_rd", rd_data, 32'h0);
        chk("arst_pend", {31'b0, evt_pending}, 32'h0);
        tick(2);
        rst = 1'b1;
        tick(2);
        chk("arst_after", {16'b0, sw_stable}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
